// File: rtl/inst_encoder_if.sv
// inst_encoder_if: field handshake plus instruction-memory write bus for the
// RV32I instruction encoder.
//   Field side : InValid/InReady handshake carrying InClass, InFn3, InFn7,
//                InRd, InRs1, InRs2, InImm.
//   Memory side: IMemWe/IMemReady handshake carrying IMemAddr, IMemWd.
// Handshake rule, both sides: the sender raises valid (InValid / IMemWe) with
// stable payload and holds both until the receiver's ready is high; a transfer
// happens on a rising edge where valid and ready are both high. Ready may
// depend on valid; valid never waits for ready.
//   master: the loader/testbench side (drives fields, acts as the memory).
//   slave : the encoder side (accepts fields, issues memory writes).
`timescale 1ns/1ps
interface inst_encoder_if #(parameter int ADDR_W = 12);
  logic              InValid;
  logic              InReady;
  logic [3:0]        InClass;
  logic [2:0]        InFn3;
  logic [6:0]        InFn7;
  logic [4:0]        InRd;
  logic [4:0]        InRs1;
  logic [4:0]        InRs2;
  logic [31:0]       InImm;
  logic              IMemWe;
  logic              IMemReady;
  logic [ADDR_W-1:0] IMemAddr;
  logic [31:0]       IMemWd;

  modport master (
    output InValid, InClass, InFn3, InFn7, InRd, InRs1, InRs2, InImm,
    input  InReady,
    input  IMemWe, IMemAddr, IMemWd,
    output IMemReady
  );

  modport slave (
    input  InValid, InClass, InFn3, InFn7, InRd, InRs1, InRs2, InImm,
    output InReady,
    output IMemWe, IMemAddr, IMemWd,
    input  IMemReady
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into 32-bit instruction words and
// writes legal words to consecutive instruction-memory word addresses.
// Ports:
//   CPU_CLK, CPU_RST_N : clock, asynchronous active-low reset
//   Start, Stop        : run control pulses (Start honoured in IDLE, Stop in RUN)
//   BaseAddr           : first word address, loaded on accepted Start
//   bus (slave)        : field handshake in, memory write handshake out
//   Busy, Done         : not idle / one-cycle pulse after draining
//   Count              : words committed since Start (saturating)
//   ErrIllegal         : sticky, some request rejected since Start
//   dbg_state          : current FSM state
// Pipeline: stage 1 registers the fields; encoding and legality are decoded
// combinationally from stage 1. Stage 2 is the memory write register.
`timescale 1ns/1ps
module inst_encoder #(parameter int ADDR_W = 12) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST_N,
  input  logic              Start,
  input  logic              Stop,
  input  logic [ADDR_W-1:0] BaseAddr,
  inst_encoder_if.slave     bus,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   Count,
  output logic              ErrIllegal,
  output logic [1:0]        dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nxt;

  // stage 1
  logic        s1_valid;
  logic [3:0]  s1_cls;
  logic [2:0]  s1_fn3;
  logic [6:0]  s1_fn7;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [31:0] s1_imm;
  // stage 2
  logic              s2_valid;
  logic [ADDR_W-1:0] s2_addr;
  logic [31:0]       s2_wd;
  logic [ADDR_W-1:0] wr_addr;   // address the next word entering stage 2 takes

  logic        legal;
  logic [31:0] word;
  logic        i_ok, b_ok, j_ok, u_ok;
  logic        s2_ready, s1_to_s2, s1_drop, in_fire, commit, done_nxt;

  // Range checks: sign-extension bits above the field must all agree.
  assign i_ok = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
  assign b_ok = ((&s1_imm[31:12]) | ~(|s1_imm[31:12])) & ~s1_imm[0];
  assign j_ok = ((&s1_imm[31:20]) | ~(|s1_imm[31:20])) & ~s1_imm[0];
  assign u_ok = ~(|s1_imm[11:0]);

  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (s1_cls)
      4'd0: begin word = {s1_imm[31:12], s1_rd, 7'b0110111}; legal = u_ok; end
      4'd1: begin word = {s1_imm[31:12], s1_rd, 7'b0010111}; legal = u_ok; end
      4'd2: begin
        word  = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, 7'b1101111};
        legal = j_ok;
      end
      4'd3: begin
        word  = {s1_imm[11:0], s1_rs1, s1_fn3, s1_rd, 7'b1100111};
        legal = i_ok && (s1_fn3 == 3'b000);
      end
      4'd4: begin
        word  = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_fn3, s1_imm[4:1], s1_imm[11], 7'b1100011};
        legal = b_ok && (s1_fn3 != 3'b010) && (s1_fn3 != 3'b011);
      end
      4'd5: begin
        word  = {s1_imm[11:0], s1_rs1, s1_fn3, s1_rd, 7'b0000011};
        legal = i_ok && (s1_fn3 != 3'b011) && (s1_fn3 != 3'b110) && (s1_fn3 != 3'b111);
      end
      4'd6: begin
        word  = {s1_imm[11:5], s1_rs2, s1_rs1, s1_fn3, s1_imm[4:0], 7'b0100011};
        legal = i_ok && (s1_fn3 <= 3'b010);
      end
      4'd7: begin
        if (s1_fn3 == 3'b001 || s1_fn3 == 3'b101) begin
          // shift-immediate: shamt in [24:20], Fn7 selects logical/arithmetic
          word  = {s1_fn7, s1_imm[4:0], s1_rs1, s1_fn3, s1_rd, 7'b0010011};
          legal = ~(|s1_imm[31:5]) &&
                  ((s1_fn3 == 3'b001) ? (s1_fn7 == 7'h00)
                                      : (s1_fn7 == 7'h00 || s1_fn7 == 7'h20));
        end else begin
          word  = {s1_imm[11:0], s1_rs1, s1_fn3, s1_rd, 7'b0010011};
          legal = i_ok;
        end
      end
      4'd8: begin
        word  = {s1_fn7, s1_rs2, s1_rs1, s1_fn3, s1_rd, 7'b0110011};
        legal = (s1_fn7 == 7'h00) ||
                (s1_fn7 == 7'h20 && (s1_fn3 == 3'b000 || s1_fn3 == 3'b101));
      end
      default: legal = 1'b0;
    endcase
  end

  assign commit      = s2_valid && bus.IMemReady;
  assign s2_ready    = !s2_valid || bus.IMemReady;
  assign s1_to_s2    = s1_valid && legal && s2_ready;
  // Illegal requests leave stage 1 immediately, independent of stage 2.
  assign s1_drop     = s1_valid && !legal;
  assign bus.InReady = (state == RUN) && (!s1_valid || s1_to_s2 || s1_drop);
  assign in_fire     = bus.InValid && bus.InReady;

  assign bus.IMemWe   = s2_valid;
  assign bus.IMemAddr = s2_addr;
  assign bus.IMemWd   = s2_wd;
  assign Busy         = (state != IDLE);
  assign dbg_state    = state;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (Start) state_nxt = RUN;
      RUN:   if (Stop)  state_nxt = DRAIN;
      DRAIN: if (!s1_valid && !s2_valid) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state <= IDLE;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Done  <= done_nxt;
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      s1_valid <= 1'b0;
      s1_cls   <= '0;
      s1_fn3   <= '0;
      s1_fn7   <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_imm   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_cls   <= bus.InClass;
      s1_fn3   <= bus.InFn3;
      s1_fn7   <= bus.InFn7;
      s1_rd    <= bus.InRd;
      s1_rs1   <= bus.InRs1;
      s1_rs2   <= bus.InRs2;
      s1_imm   <= bus.InImm;
    end else if (s1_to_s2 || s1_drop) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      s2_valid   <= 1'b0;
      s2_addr    <= '0;
      s2_wd      <= '0;
      wr_addr    <= '0;
      Count      <= '0;
      ErrIllegal <= 1'b0;
    end else begin
      if (s1_to_s2) begin
        s2_valid <= 1'b1;
        s2_addr  <= wr_addr;
        s2_wd    <= word;
        wr_addr  <= wr_addr + 1'b1;   // wraps naturally at 2^ADDR_W
      end else if (commit) begin
        s2_valid <= 1'b0;
      end
      if (commit && !Count[ADDR_W])
        Count <= Count + 1'b1;
      if (s1_drop)
        ErrIllegal <= 1'b1;
      // Start is only honoured in IDLE, where both stages are empty, so it
      // never races a commit or a rejection.
      if (state == IDLE && Start) begin
        wr_addr    <= BaseAddr;
        Count      <= '0;
        ErrIllegal <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
module tb_inst_encoder;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy, done, err;
  logic [ADDR_W:0]   count;
  logic [1:0]        dbg_state;

  inst_encoder_if #(.ADDR_W(ADDR_W)) bus();

  inst_encoder #(.ADDR_W(ADDR_W)) dut (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .Start(start), .Stop(stop),
    .BaseAddr(base_addr), .bus(bus), .Busy(busy), .Done(done),
    .Count(count), .ErrIllegal(err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_wd[$];
  int unsigned       cap_cyc[$];
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // commit monitor: a write with ready seen mid-cycle commits on the next edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.IMemWe && bus.IMemReady) begin
        cap_addr.push_back(bus.IMemAddr);
        cap_wd.push_back(bus.IMemWd);
        cap_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [ADDR_W-1:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic send(input logic [3:0] cls, input logic [2:0] fn3, input logic [6:0] fn7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    bit acc = 0;
    bus.InValid = 1'b1; bus.InClass = cls; bus.InFn3 = fn3; bus.InFn7 = fn7;
    bus.InRd = rd; bus.InRs1 = rs1; bus.InRs2 = rs2; bus.InImm = imm;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (bus.InReady) acc = 1;
      @(posedge clk); #1;
    end
    bus.InValid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: InReady=0 for 200 cycles, required 1");
    end
  endtask

  task automatic wait_commits(input int n);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cap_addr.size() >= n) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL commit_timeout: got %0d commits, required %0d", cap_addr.size(), n);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: Busy still 1 after 50 cycles");
    end
  endtask

  task automatic clear_caps();
    cap_addr.delete(); cap_wd.delete(); cap_cyc.delete();
    exp_q.delete(); exp_addr_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.IMemWe !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.IMemWe); end
    checks++; if (bus.IMemAddr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", bus.IMemAddr); end
    checks++; if (bus.IMemWd !== 32'h0) begin errors++; $display("FAIL reset_wd: got %h want 0", bus.IMemWd); end
    checks++; if (bus.InReady !== 1'b0) begin errors++; $display("FAIL reset_inready: got %b want 0", bus.InReady); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (count !== 13'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_caps();
    bus.IMemReady = 1'b1;
    do_start(12'h010);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    send(4'd7, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    wait_commits(1);
    checks++; if (cap_wd[0] !== 32'h00500093) begin errors++; $display("FAIL basic_wd: got %h want 00500093", cap_wd[0]); end
    checks++; if (cap_addr[0] !== 12'h010) begin errors++; $display("FAIL basic_addr: got %h want 010", cap_addr[0]); end
    checks++; if (count !== 13'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", count); end
  endtask

  task automatic test_back_to_back();
    clear_caps();
    exp_q = '{32'h0020A423, 32'hFE208CE3, 32'h001000EF};
    exp_addr_q = '{12'h011, 12'h012, 12'h013};
    send(4'd6, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
    send(4'd4, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    send(4'd2, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
    wait_commits(3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (cap_wd[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_wd[%0d]: got %h want %h", i, cap_wd[i], exp_q[i]); end
      checks++; if (cap_addr[i] !== exp_addr_q[i]) begin errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, cap_addr[i], exp_addr_q[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (cap_cyc[i] - cap_cyc[i-1] !== 1) begin
        errors++; $display("FAIL b2b_rate[%0d]: gap %0d cycles want 1", i, cap_cyc[i] - cap_cyc[i-1]);
      end
    end
  endtask

  task automatic test_shift_lui();
    clear_caps();
    exp_q = '{32'h4041D193, 32'h123452B7};
    exp_addr_q = '{12'h014, 12'h015};
    send(4'd7, 3'b101, 7'h20, 5'd3, 5'd3, 5'd0, 32'd4);
    send(4'd0, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);
    wait_commits(2);
    for (int i = 0; i < 2; i++) begin
      checks++; if (cap_wd[i] !== exp_q[i]) begin errors++; $display("FAIL shlui_wd[%0d]: got %h want %h", i, cap_wd[i], exp_q[i]); end
      checks++; if (cap_addr[i] !== exp_addr_q[i]) begin errors++; $display("FAIL shlui_addr[%0d]: got %h want %h", i, cap_addr[i], exp_addr_q[i]); end
    end
    checks++; if (count !== 13'd6) begin errors++; $display("FAIL shlui_count: got %0d want 6", count); end
  endtask

  task automatic test_illegal();
    clear_caps();
    send(4'd7, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(4'd4, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", err); end
    checks++; if (count !== 13'd6) begin errors++; $display("FAIL illegal_count: got %0d want 6", count); end
    checks++; if (cap_addr.size() !== 0) begin errors++; $display("FAIL illegal_leak: got %0d writes want 0", cap_addr.size()); end
    // add x1, x2, x3
    send(4'd8, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
    wait_commits(1);
    checks++; if (cap_wd[0] !== 32'h003100B3) begin errors++; $display("FAIL illegal_next_wd: got %h want 003100B3", cap_wd[0]); end
    checks++; if (cap_addr[0] !== 12'h016) begin errors++; $display("FAIL illegal_next_addr: got %h want 016", cap_addr[0]); end
  endtask

  task automatic test_backpressure();
    clear_caps();
    exp_q = '{32'h00100093, 32'h00200113, 32'h00300193};
    exp_addr_q = '{12'h017, 12'h018, 12'h019};
    bus.IMemReady = 1'b0;
    send(4'd7, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    send(4'd7, 3'b000, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2);
    fork
      send(4'd7, 3'b000, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.IMemWe !== 1'b1) begin errors++; $display("FAIL bp_we[%0d]: got %b want 1", i, bus.IMemWe); end
      checks++; if (bus.IMemAddr !== 12'h017) begin errors++; $display("FAIL bp_addr[%0d]: got %h want 017", i, bus.IMemAddr); end
      checks++; if (bus.IMemWd !== 32'h00100093) begin errors++; $display("FAIL bp_wd[%0d]: got %h want 00100093", i, bus.IMemWd); end
      checks++; if (bus.InReady !== 1'b0) begin errors++; $display("FAIL bp_inready[%0d]: got %b want 0", i, bus.InReady); end
    end
    @(posedge clk); #1;
    bus.IMemReady = 1'b1;
    wait_commits(3);
    wait fork;
    for (int i = 0; i < 3; i++) begin
      checks++; if (cap_wd[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order_wd[%0d]: got %h want %h", i, cap_wd[i], exp_q[i]); end
      checks++; if (cap_addr[i] !== exp_addr_q[i]) begin errors++; $display("FAIL bp_order_addr[%0d]: got %h want %h", i, cap_addr[i], exp_addr_q[i]); end
    end
    checks++; if (count !== 13'd10) begin errors++; $display("FAIL bp_count: got %0d want 10", count); end
  endtask

  task automatic test_wrap_stop();
    do_stop();
    wait_idle();
    clear_caps();
    do_start(12'hFFF);
    done_cnt = 0;
    checks++; if (count !== 13'd0) begin errors++; $display("FAIL wrap_count_clr: got %0d want 0", count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err_clr: got %b want 0", err); end
    exp_q = '{32'h00500093, 32'h00100093};
    exp_addr_q = '{12'hFFF, 12'h000};
    send(4'd7, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    send(4'd7, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    do_stop();
    wait_commits(2);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (cap_wd[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_wd[%0d]: got %h want %h", i, cap_wd[i], exp_q[i]); end
      checks++; if (cap_addr[i] !== exp_addr_q[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, cap_addr[i], exp_addr_q[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (count !== 13'd2) begin errors++; $display("FAIL wrap_count: got %0d want 2", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_write();
    clear_caps();
    bus.IMemReady = 1'b0;
    do_start(12'h020);
    send(4'd7, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.IMemWe !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", bus.IMemWe); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.IMemWe !== 1'b0) begin errors++; $display("FAIL mid_we: got %b want 0", bus.IMemWe); end
    checks++; if (bus.IMemAddr !== 12'h000) begin errors++; $display("FAIL mid_addr: got %h want 000", bus.IMemAddr); end
    checks++; if (bus.IMemWd !== 32'h0) begin errors++; $display("FAIL mid_wd: got %h want 0", bus.IMemWd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (count !== 13'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", count); end
    checks++; if (bus.InReady !== 1'b0) begin errors++; $display("FAIL mid_inready: got %b want 0", bus.InReady); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.IMemReady = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (cap_addr.size() !== 0) begin errors++; $display("FAIL mid_lost_word: got %0d writes want 0", cap_addr.size()); end
  endtask

  initial begin
    bus.InValid = 1'b0; bus.InClass = '0; bus.InFn3 = '0; bus.InFn7 = '0;
    bus.InRd = '0; bus.InRs1 = '0; bus.InRs2 = '0; bus.InImm = '0;
    bus.IMemReady = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_shift_lui();
    test_illegal();
    test_backpressure();
    test_wrap_stop();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

RV32I instruction encoder and instruction-memory writer; the inverse of the ID-stage decoder. It accepts decoded instruction fields (class, Fn3, Fn7, register indices, immediate) over a valid/ready handshake, packs them into 32-bit RV32I words, rejects illegal combinations, and writes legal words to consecutive instruction-memory word addresses. Used by the debug/program-loader path to fill instruction RAM before or between CPU runs.

## Interface
- ADDR_W, 12, instruction-memory word-address width
- CPU_CLK  in  1  clock; all state on rising edge
- CPU_RST_N  in  1  reset; asynchronous, active-low
- Start  in  1  pulse: load base address, clear counters/flags, enter RUN (honoured only in IDLE)
- Stop  in  1  pulse: stop accepting, drain pipeline, return to IDLE (honoured only in RUN)
- BaseAddr  in  ADDR_W  first word address, sampled on accepted Start
- InValid / InReady  in / out  1  field handshake; transfer when both high
- InClass  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP; 9-15 illegal
- InFn3 / InFn7  in  3 / 7  funct fields
- InRd / InRs1 / InRs2  in  5 each  register indices (unused ones ignored)
- InImm  in  32  immediate as the signed byte value (U-type: full value, low 12 bits zero)
- IMemWe  out  1  write request; held until IMemReady
- IMemReady  in  1  memory accepts write this cycle
- IMemAddr  out  ADDR_W  word address
- IMemWd  out  32  encoded word
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle pulse on DRAIN->IDLE
- Count  out  ADDR_W+1  words committed since Start
- ErrIllegal  out  1  sticky: at least one request rejected since Start

## Operation
- FSM IDLE -> RUN (Start) -> DRAIN (Stop) -> IDLE (pipeline empty, Done=1). Start in RUN/DRAIN and Stop in IDLE/DRAIN ignored. Start and Stop together in IDLE: Start wins.
- InReady=1 only in RUN and when stage 1 is empty or moving to stage 2.
- Stage 1 registers fields; encoding and legality are combinational from stage 1. Stage 2 holds IMemWd/IMemAddr/IMemWe.
- Formats: R/I/S/B/U/J per RV32I; opcode from InClass; B uses InImm[12:1], J uses InImm[20:1]; OPIMM shifts (Fn3 001/101) place InImm[4:0] at [24:20] and InFn7 at [31:25].
- Illegal: InClass>8; JALR Fn3!=0; BRANCH Fn3 010/011; LOAD Fn3 011/110/111; STORE Fn3>010; OP Fn7 not 0000000/0100000, or 0100000 with Fn3 not 000/101; OPIMM Fn3 001 with Fn7!=0, Fn3 101 with Fn7 not 0000000/0100000, shift InImm[31:5]!=0; I/S immediate outside -2048..2047; B outside -4096..4094 or odd; J outside ±1 MiB or odd; U with InImm[11:0]!=0.
- Illegal request: discarded in stage 1 (never reaches stage 2), ErrIllegal<=1, address and Count unchanged.
- Commit = IMemWe&&IMemReady: address+1 (wraps 2^ADDR_W-1 -> 0), Count+1 (saturates at 2^ADDR_W).
- Accepted Start: address<=BaseAddr, Count<=0, ErrIllegal<=0.

## Timing
- Reset: state IDLE, both stages empty, IMemWe=0, IMemAddr=0, IMemWd=0, InReady=0, Busy=0, Done=0, Count=0, ErrIllegal=0.
- Latency: accepted at edge N -> IMemWe=1 after edge N+1; commit at first edge with IMemReady=1.
- Full throughput with IMemReady held 1: one word per cycle.
- Backpressure: while IMemWe&&!IMemReady, IMemAddr/IMemWd stable; stage 1 holds; InReady=0 if stage 1 full.
- Stop in same cycle as a transfer: transfer accepted, then DRAIN.
- DRAIN exits on the edge when both stages are empty; Done high the following cycle only.
- Reset asserted mid-write: all state cleared immediately; pending word lost.

## Test plan
- Start BaseAddr=0x010, OPIMM Fn3=000 Rd=1 Rs1=0 Imm=5 -> IMemWd=0x00500093 at addr 0x010, Count=1.
- Back-to-back, IMemReady=1: STORE Fn3=010 Rs1=1 Rs2=2 Imm=8 -> 0x0020A423; BRANCH Fn3=000 Rs1=1 Rs2=2 Imm=-8 -> 0xFE208CE3; JAL Rd=1 Imm=2048 -> 0x001000EF; addresses consecutive, one per cycle.
- OPIMM Fn3=101 Fn7=0100000 Rd=3 Rs1=3 Imm=4 -> 0x4041D193; LUI Rd=5 Imm=0x12345000 -> 0x123452B7.
- OPIMM Fn3=000 Imm=2048, then BRANCH Imm=3 -> both dropped, ErrIllegal=1, Count unchanged; next legal word at unchanged address.
- IMemReady low 5 cycles with 3 pending requests -> IMemWd/IMemAddr stable, InReady=0, no loss; all commit in order after release.
- BaseAddr=0xFFF, two words then Stop -> addresses 0xFFF, 0x000; Done pulses once; CPU_RST_N low during a stalled write clears all outputs.
